tsg: RTL and testbench

Two-sequence generator: serially transmits the framed patterns 1011 or 10010 on a single-bit line, MSB first, for a requested number of repetitions. It is the transmit-side partner of the two-sequence detector, whose `x`/`clk`/`reset` it drives directly in loopback and system benches. Inter-frame idle gaps are inserted so every frame is detected: the detector swallows the bit that follows a completed match.

---
 rtl/tsg.sv | 180 ++++++++++++++++++
 tb/tb_tsg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tsg.sv
`default_nettype none
// ============================================================================
// Module   : tsg
// Purpose  : Two-sequence generator. Serially transmits the framed patterns
//            1011 (sel=0) or 10010 (sel=1), MSB first, for a requested number
//            of frames. Frames are separated by GAP idle zero cycles, and a
//            final FIN cycle drives a zero bit and pulses done.
// Ports    : clk       - rising-edge clock
//            reset     - synchronous, active-high reset
//            start     - run request, sampled only in IDLE
//            sel       - pattern select, latched at start
//            count     - number of frames (0 treated as 1), latched at start
//            abort     - cancel the run in SEND/GAP (TSG_ABORT_EN builds only)
//            x         - serial data, 0 outside frame bits
//            valid     - x carries a frame bit
//            busy      - first frame bit through the FIN cycle
//            frame_end - last bit of each frame
//            done      - one-cycle pulse in FIN
// Config   : define TSG_ABORT_EN to add the abort port and its behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tsg #(
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sel,
    input  logic [CNT_W-1:0] count,
`ifdef TSG_ABORT_EN
    input  logic             abort,
`endif
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             frame_end,
    output logic             done
);

    localparam int c_gap_w = $clog2(GAP + 1);

    // Patterns stored with frame bit index i at vector bit i.
    // 1011  -> idx0..3 = 1,0,1,1
    // 10010 -> idx0..4 = 1,0,0,1,0
    localparam logic [4:0]         c_pat_a   = 5'b01101;
    localparam logic [4:0]         c_pat_b   = 5'b01001;
    localparam logic [CNT_W-1:0]   c_one     = CNT_W'(1);
    localparam logic [c_gap_w-1:0] c_gap_one = c_gap_w'(1);
    localparam logic [c_gap_w-1:0] c_gap_ld  = c_gap_w'(GAP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_sel;
    logic [CNT_W-1:0]     r_rem;
    logic [2:0]           r_bit_idx;
    logic [c_gap_w-1:0]   r_gap_cnt;

    logic [4:0]           w_pat;
    logic [2:0]           w_last;
    logic [2:0]           w_next_idx;
    logic                 w_abort;

    assign w_pat      = r_sel ? c_pat_b : c_pat_a;
    assign w_last     = r_sel ? 3'd4 : 3'd3;
    assign w_next_idx = r_bit_idx + 3'd1;

`ifdef TSG_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Outputs are registered alongside the state: every branch assigns the
    // output values that belong to the state being entered, so they are valid
    // in the same cycle as that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel     <= 1'b0;
            r_rem     <= '0;
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
            x         <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_end <= 1'b0;
            done      <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    x     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        r_state   <= S_SEND;
                        r_sel     <= sel;
                        r_rem     <= (count == '0) ? c_one : count;
                        r_bit_idx <= '0;
                        // Both patterns begin with a 1, so the first bit does
                        // not depend on the select being latched this edge.
                        x         <= 1'b1;
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (w_abort) begin
                        r_state   <= S_IDLE;
                        r_rem     <= '0;
                        r_bit_idx <= '0;
                        r_gap_cnt <= '0;
                        x         <= 1'b0;
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                    end else if (r_bit_idx == w_last) begin
                        r_rem <= r_rem - c_one;
                        x     <= 1'b0;
                        valid <= 1'b0;
                        if (r_rem == c_one) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= c_gap_ld;
                        end
                    end else begin
                        r_bit_idx <= w_next_idx;
                        x         <= w_pat[w_next_idx];
                        frame_end <= (w_next_idx == w_last);
                    end
                end

                S_GAP: begin
                    if (w_abort) begin
                        r_state   <= S_IDLE;
                        r_rem     <= '0;
                        r_bit_idx <= '0;
                        r_gap_cnt <= '0;
                        x         <= 1'b0;
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                    end else if (r_gap_cnt == c_gap_one) begin
                        r_state   <= S_SEND;
                        r_bit_idx <= '0;
                        x         <= 1'b1;
                        valid     <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_gap_one;
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                    x       <= 1'b0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    x       <= 1'b0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tsg.sv
`default_nettype none
// ============================================================================
// Module   : tb_tsg
// Purpose  : Self-checking bench for tsg. Stimulus pushes the expected
//            per-cycle output tuples of each run into a queue; a monitor pops
//            and compares whenever the generator reports busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tsg;

    localparam int CNT_W = 4;
    localparam int GAP   = 2;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             sel   = 1'b0;
    logic [CNT_W-1:0] count = '0;
`ifdef TSG_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             x;
    logic             valid;
    logic             busy;
    logic             frame_end;
    logic             done;

    tsg #(.CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sel       (sel),
        .count     (count),
`ifdef TSG_ABORT_EN
        .abort     (abort),
`endif
        .x         (x),
        .valid     (valid),
        .busy      (busy),
        .frame_end (frame_end),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Tuple layout: {x, valid, busy, frame_end, done}
    logic [4:0] exp_q[$];

    function automatic int run_len(input logic s, input int c);
        int n;
        int l;
        n = (c == 0) ? 1 : c;
        l = s ? 5 : 4;
        return n * l + (n - 1) * GAP + 1;
    endfunction

    // Reference stream: frames MSB first, GAP zero cycles between frames,
    // one trailing FIN cycle carrying done.
    task automatic push_run(input logic s, input int c);
        logic [4:0] pat;
        int n;
        int l;
        pat = s ? 5'b10010 : 5'b10110;
        n   = (c == 0) ? 1 : c;
        l   = s ? 5 : 4;
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < l; b++)
                exp_q.push_back({pat[4 - b], 1'b1, 1'b1, (b == l - 1), 1'b0});
            if (f < n - 1)
                for (int g = 0; g < GAP; g++)
                    exp_q.push_back(5'b00100);
        end
        exp_q.push_back(5'b00101);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: samples 1 time unit after each active edge.
    initial begin
        logic [4:0] act;
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            act = {x, valid, busy, frame_end, done};
            checks++;
            if (busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_busy got=%b want=idle", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL stream got=%b want=%b", act, e);
                    end
                end
            end else if (act !== 5'b00000) begin
                errors++;
                $display("FAIL idle_outputs got=%b want=00000", act);
            end
        end
    end

    // Issue one run from IDLE and confirm its length from start to done.
    task automatic run_one(input logic s, input int c);
        int cyc;
        sel   = s;
        count = CNT_W'(c);
        start = 1'b1;
        push_run(s, c);
        @(negedge clk);
        start = 1'b0;
        // Later changes must not affect the run in flight.
        sel   = 1'($urandom);
        count = CNT_W'($urandom);
        cyc   = 1;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_len", cyc, run_len(s, c));
        @(negedge clk);
        chk("busy_after_fin", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic s;

        repeat (3) @(negedge clk);
        chk("reset_state", {x, valid, busy, frame_end, done}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed runs including count=0 and maximum count.
        run_one(1'b0, 1);
        run_one(1'b1, 3);
        run_one(1'b0, 0);
        run_one(1'b1, 0);
        run_one(1'b0, 15);

        // start held high, sel toggled during the run.
        sel   = 1'b0;
        count = CNT_W'(2);
        start = 1'b1;
        push_run(1'b0, 2);
        @(negedge clk);
        cyc = 1;
        while (done !== 1'b1 && cyc < 400) begin
            sel   = 1'($urandom);
            count = CNT_W'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("held_run_len", cyc, run_len(1'b0, 2));
        @(negedge clk);
        chk("held_idle_gap", busy, 0);
        sel   = 1'b1;
        count = CNT_W'(1);
        push_run(1'b1, 1);
        @(negedge clk);
        start = 1'b0;
        chk("held_second_first_bit", {x, valid}, 2'b11);
        cyc = 1;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_second_len", cyc, run_len(1'b1, 1));
        @(negedge clk);
        chk("held_queue_drained", exp_q.size(), 0);

        // Reset during bit index 2 of a count=2 run.
        s     = 1'($urandom);
        sel   = s;
        count = CNT_W'(2);
        start = 1'b1;
        push_run(s, 2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_outputs", {x, valid, busy, frame_end, done}, 0);
        repeat (12) @(negedge clk);

`ifdef TSG_ABORT_EN
        // Abort in the first gap of a count=4 run.
        s     = 1'($urandom);
        sel   = s;
        count = CNT_W'(4);
        start = 1'b1;
        push_run(s, 4);
        @(negedge clk);
        start = 1'b0;
        repeat (s ? 5 : 4) @(negedge clk);
        chk("abort_in_gap", {valid, busy}, 2'b01);
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", {x, valid, busy, frame_end, done}, 0);
        repeat (12) @(negedge clk);
`endif

        // Randomized runs.
        for (int i = 0; i < 10; i++)
            run_one(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
